// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the single-clock UART core.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Rounded clocks per oversampling tick.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

    // Parity bit for a payload zero-extended to 9 bits (extension does not alter parity).
    function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running clock-enable generator: one-cycle tick every DIV clocks.
module uart_tick_gen #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int CW = $clog2(DIV) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Divider next-state: wrap and pulse on the last count.
    always_comb begin
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/uart_core_p.sv
// Single-clock full-duplex UART: TX serialiser and oversampling RX deserialiser
// driven by a shared tick enable, with internal loopback.
module uart_core_p
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 100_000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    input  logic                 i_rx,
    input  logic                 i_loopback,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_busy
);
    localparam int            DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            CW        = $clog2(OVERSAMPLE);
    localparam parity_e       PAR       = parity_e'(PARITY);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_core_p: illegal parameter combination");
    end

    logic tick_s;

    uart_tick_gen #(.DIV(DIV)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick_s)
    );

    tx_state_e              tx_state_q, tx_state_d;
    logic                   tx_run_q, tx_run_d;
    logic [CW-1:0]          tx_tcnt_q, tx_tcnt_d;
    logic [3:0]             tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_line_q, tx_line_d;
    logic                   tx_out_q, tx_out_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_bit_end_s;

    // TX next-state: tx_run gates bit timing until the start bit has aligned to a tick.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_run_d     = tx_run_q;
        tx_bcnt_d    = tx_bcnt_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        tx_line_d    = tx_line_q;
        tx_bit_end_s = 1'b0;
        if (tx_run_q && tick_s) begin
            if (tx_tcnt_q == LAST_TICK) begin
                tx_tcnt_d    = '0;
                tx_bit_end_s = 1'b1;
            end else begin
                tx_tcnt_d = tx_tcnt_q + CW'(1);
            end
        end else begin
            tx_tcnt_d = tx_tcnt_q;
        end
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (i_tx_valid) begin
                    tx_shift_d = i_tx_data;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (!tx_run_q && tick_s) begin
                    tx_run_d  = 1'b1;
                    tx_line_d = 1'b0;
                end else if (tx_bit_end_s) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_par_d   = calc_parity(9'(tx_shift_q), PAR);
                    tx_bcnt_d  = 4'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s && tx_bcnt_q == LAST_DATA) begin
                    tx_bcnt_d  = 4'd0;
                    tx_line_d  = (PAR != PAR_NONE) ? tx_par_q : 1'b1;
                    tx_state_d = (PAR != PAR_NONE) ? TX_PARITY : TX_STOP;
                end else if (tx_bit_end_s) begin
                    tx_bcnt_d  = tx_bcnt_q + 4'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_line_d  = tx_shift_q[1];
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end_s) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_bit_end_s && tx_bcnt_q == LAST_STOP) begin
                    tx_run_d   = 1'b0;
                    tx_state_d = TX_IDLE;
                end else if (tx_bit_end_s) begin
                    tx_bcnt_d = tx_bcnt_q + 4'd1;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_run_d   = 1'b0;
                tx_line_d  = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
        tx_out_d   = tx_line_d | i_loopback;
        tx_ready_d = (tx_state_d == TX_IDLE);
        tx_busy_d  = (tx_state_d != TX_IDLE);
    end

    // TX state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state_q <= TX_IDLE;
            tx_run_q   <= 1'b0;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= 4'd0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_run_q   <= tx_run_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    rx_state_e              rx_state_q, rx_state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_sync_q, rx_sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [CW-1:0]          rx_tcnt_q, rx_tcnt_d;
    logic [3:0]             rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_pend_q, rx_pend_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_busy_q, rx_busy_d;
    logic                   rx_sample_s;

    // RX next-state: first sample at half a bit into the start bit, then once per bit.
    always_comb begin
        rx_meta_d   = i_loopback ? tx_line_q : i_rx;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        rx_state_d  = rx_state_q;
        rx_bcnt_d   = rx_bcnt_q;
        rx_shift_d  = rx_shift_q;
        rx_pend_d   = rx_pend_q;
        rx_data_d   = rx_data_q;
        rx_perr_d   = rx_perr_q;
        rx_ferr_d   = rx_ferr_q;
        rx_valid_d  = 1'b0;
        rx_sample_s = 1'b0;
        if (rx_state_q == RX_IDLE) begin
            rx_tcnt_d = '0;
        end else if (tick_s) begin
            if (rx_tcnt_q == ((rx_state_q == RX_START) ? HALF_TICK : LAST_TICK)) begin
                rx_tcnt_d   = '0;
                rx_sample_s = 1'b1;
            end else begin
                rx_tcnt_d = rx_tcnt_q + CW'(1);
            end
        end else begin
            rx_tcnt_d = rx_tcnt_q;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_bcnt_d  = 4'd0;
                    rx_pend_d  = 1'b0;
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_sample_s) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_sample_s) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bcnt_q == LAST_DATA) begin
                        rx_state_d = (PAR != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bcnt_d = rx_bcnt_q + 4'd1;
                    end
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_sample_s) begin
                    rx_pend_d  = (rx_sync_q != calc_parity(9'(rx_shift_q), PAR));
                    rx_state_d = RX_STOP;
                end else begin
                    rx_state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_sample_s) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = rx_pend_q;
                    rx_ferr_d  = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
        rx_busy_d = (rx_state_d != RX_IDLE);
    end

    // RX state register; synchroniser flops reset to the idle line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state_q <= RX_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= 4'd0;
            rx_shift_q <= '0;
            rx_pend_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_shift_q <= rx_shift_d;
            rx_pend_q  <= rx_pend_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign o_tx            = tx_out_q;
    assign o_tx_ready      = tx_ready_q;
    assign o_tx_busy       = tx_busy_q;
    assign o_rx_data       = rx_data_q;
    assign o_rx_valid      = rx_valid_q;
    assign o_rx_parity_err = rx_perr_q;
    assign o_rx_frame_err  = rx_ferr_q;
    assign o_rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_core_p.sv
// Bench for uart_core_p: four instances (8N1, 8E1 loopback, 8O1, 9O2 loopback)
// checked against frame-level expectations derived from the UART framing rules.
module tb_uart_core_p;

    localparam int BT = 160;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rx_line;
    int   rx_sel;

    logic [7:0] n1_txd, e1_txd, o1_txd, n1_rxd, e1_rxd, o1_rxd;
    logic [8:0] n9_txd, n9_rxd;
    logic n1_tv, n1_tr, n1_tx, n1_tb, n1_rx, n1_rv, n1_pe, n1_fe, n1_rb;
    logic e1_tv, e1_tr, e1_tx, e1_tb, e1_rv, e1_pe, e1_fe, e1_rb;
    logic o1_tv, o1_tr, o1_tx, o1_tb, o1_rx, o1_rv, o1_pe, o1_fe, o1_rb;
    logic n9_tv, n9_tr, n9_tx, n9_tb, n9_rv, n9_pe, n9_fe, n9_rb;

    assign n1_rx = (rx_sel == 1) ? rx_line : 1'b1;
    assign o1_rx = (rx_sel == 2) ? rx_line : 1'b1;

    uart_core_p #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(n1_txd), .i_tx_valid(n1_tv), .o_tx_ready(n1_tr),
        .o_tx(n1_tx), .o_tx_busy(n1_tb), .i_rx(n1_rx), .i_loopback(1'b0), .o_rx_data(n1_rxd),
        .o_rx_valid(n1_rv), .o_rx_parity_err(n1_pe), .o_rx_frame_err(n1_fe), .o_rx_busy(n1_rb));
    uart_core_p #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(e1_txd), .i_tx_valid(e1_tv), .o_tx_ready(e1_tr),
        .o_tx(e1_tx), .o_tx_busy(e1_tb), .i_rx(1'b0), .i_loopback(1'b1), .o_rx_data(e1_rxd),
        .o_rx_valid(e1_rv), .o_rx_parity_err(e1_pe), .o_rx_frame_err(e1_fe), .o_rx_busy(e1_rb));
    uart_core_p #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o1 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(o1_txd), .i_tx_valid(o1_tv), .o_tx_ready(o1_tr),
        .o_tx(o1_tx), .o_tx_busy(o1_tb), .i_rx(o1_rx), .i_loopback(1'b0), .o_rx_data(o1_rxd),
        .o_rx_valid(o1_rv), .o_rx_parity_err(o1_pe), .o_rx_frame_err(o1_fe), .o_rx_busy(o1_rb));
    uart_core_p #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_n9 (
        .i_clk(clk), .i_rst(rst), .i_tx_data(n9_txd), .i_tx_valid(n9_tv), .o_tx_ready(n9_tr),
        .o_tx(n9_tx), .o_tx_busy(n9_tb), .i_rx(1'b1), .i_loopback(1'b1), .o_rx_data(n9_rxd),
        .o_rx_valid(n9_rv), .o_rx_parity_err(n9_pe), .o_rx_frame_err(n9_fe), .o_rx_busy(n9_rb));

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t q_n1[$], q_e1[$], q_o1[$], q_n9[$];
    int   e1_tx_low = 0;

    // Capture every received frame of each instance.
    always @(negedge clk) begin
        if (n1_rv) q_n1.push_back({1'b0, n1_rxd, n1_pe, n1_fe});
        if (e1_rv) q_e1.push_back({1'b0, e1_rxd, e1_pe, e1_fe});
        if (o1_rv) q_o1.push_back({1'b0, o1_rxd, o1_pe, o1_fe});
        if (n9_rv) q_n9.push_back({n9_rxd, n9_pe, n9_fe});
        if (!e1_tx) e1_tx_low <= e1_tx_low + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            1:       return q_n1.size();
            2:       return q_e1.size();
            3:       return q_o1.size();
            4:       return q_n9.size();
            default: return 0;
        endcase
    endfunction

    function automatic rec_t pop_q(input int which);
        rec_t r;
        r = '0;
        case (which)
            1:       if (q_n1.size() > 0) r = q_n1.pop_front();
            2:       if (q_e1.size() > 0) r = q_e1.pop_front();
            3:       if (q_o1.size() > 0) r = q_o1.pop_front();
            4:       if (q_n9.size() > 0) r = q_n9.pop_front();
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic wait_count(input int which, input int n, input int budget, input string name);
        int k = 0;
        while (qsize(which) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (qsize(which) < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d frames expected %0d", name, qsize(which), n);
        end
    endtask

    task automatic expect_frame(input int which, input string name, input logic [8:0] d,
                                input logic pe, input logic fe);
        rec_t r;
        r = pop_q(which);
        check({name, "_data"}, r.d, d);
        check({name, "_perr"}, r.pe, pe);
        check({name, "_ferr"}, r.fe, fe);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (BT) @(negedge clk);
    endtask

    // Serial frame built from the framing rules: start, LSB-first data, parity, stop, idle.
    task automatic send_ext(input int sel, input logic [8:0] d, input int nbits, input int par,
                            input logic bad_par, input logic bad_stop);
        int   ones = 0;
        logic pb;
        rx_sel = sel;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(d[i]);
            ones += int'(d[i]);
        end
        if (par != 0) begin
            pb = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            drive_bit(pb ^ bad_par);
        end
        drive_bit(!bad_stop);
        drive_bit(1'b1);
    endtask

    task automatic send_e1(input logic [7:0] d);
        int k = 0;
        while (!e1_tr && k < 5000) begin
            @(negedge clk);
            k++;
        end
        e1_txd = d;
        e1_tv  = 1'b1;
        @(negedge clk);
        e1_tv  = 1'b0;
    endtask

    logic [8:0] n9_buf[8];

    // Hold valid high across frames so each new word is taken the cycle ready returns.
    task automatic n9_burst(input int n);
        n9_tv = 1'b1;
        for (int i = 0; i < n; i++) begin
            int k = 0;
            n9_txd = n9_buf[i];
            while (!n9_tr && k < 4000) begin
                @(negedge clk);
                k++;
            end
            @(negedge clk);
        end
        n9_tv = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       bp;
        logic       bs;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int         t0, k;
        logic       b;
        logic [7:0] a5, rd;
        logic       rbp, rbs;

        rst = 1'b1; rx_line = 1'b1; rx_sel = 0;
        n1_tv = 1'b0; e1_tv = 1'b0; o1_tv = 1'b0; n9_tv = 1'b0;
        n1_txd = 8'h00; e1_txd = 8'h00; o1_txd = 8'h00; n9_txd = 9'h000;
        repeat (3) @(negedge clk);
        check("rst_tx", n1_tx, 1'b1);
        check("rst_ready", n1_tr, 1'b1);
        check("rst_tx_busy", n1_tb, 1'b0);
        check("rst_rx_valid", n1_rv, 1'b0);
        check("rst_rx_data", n1_rxd, 8'h00);
        check("rst_rx_flags", {n1_pe, n1_fe, n1_rb}, 3'b000);
        check("rst_n9_ready", n9_tr, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 waveform and exact bit / ready timing.
        a5 = 8'hA5;
        n1_txd = a5; n1_tv = 1'b1;
        @(negedge clk);
        n1_tv = 1'b0;
        check("a5_ready_drop", n1_tr, 1'b0);
        k = 0;
        while (n1_tx && k < 50) begin @(negedge clk); k++; end
        check("a5_start_seen", n1_tx, 1'b0);
        t0 = cyc;
        wait_until(t0 + BT - 1);
        check("a5_start_width", n1_tx, 1'b0);
        wait_until(t0 + BT);
        check("a5_bit0_edge", n1_tx, a5[0]);
        for (int i = 1; i < 10; i++) begin
            b = (i <= 8) ? a5[i-1] : 1'b1;
            wait_until(t0 + i * BT + BT / 2);
            check($sformatf("a5_bit%0d", i), n1_tx, b);
        end
        while (!n1_tr && cyc < t0 + 2000) @(negedge clk);
        check("a5_ready_time", cyc - t0, 1600);
        check("a5_busy_end", n1_tb, 1'b0);

        // 8E1 loopback 0x3C.
        send_e1(8'h3C);
        wait_count(2, 1, 2500, "lb_3c");
        repeat (300) @(negedge clk);
        check("lb_3c_count", qsize(2), 1);
        expect_frame(2, "lb_3c", 9'h03C, 1'b0, 1'b0);
        check("lb_tx_held_high", e1_tx_low, 0);

        // 8O1 external frames from the vector table.
        tbl[0] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[1] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send_ext(2, {1'b0, tbl[i].d}, 8, 1, tbl[i].bp, tbl[i].bs);
            wait_count(3, 1, 200, $sformatf("tbl%0d", i));
            expect_frame(3, $sformatf("tbl%0d", i), {1'b0, tbl[i].ed}, tbl[i].ep, tbl[i].ef);
        end

        // 8N1 external 0xFF with low stop bit.
        send_ext(1, 9'h0FF, 8, 0, 1'b0, 1'b1);
        wait_count(1, 1, 200, "stop_low");
        expect_frame(1, "stop_low", 9'h0FF, 1'b0, 1'b1);

        // 40-clock low glitch must be rejected as a false start.
        rx_sel = 1; rx_line = 1'b0;
        repeat (20) @(negedge clk);
        check("false_busy_on", n1_rb, 1'b1);
        repeat (20) @(negedge clk);
        rx_line = 1'b1;
        repeat (200) @(negedge clk);
        check("false_busy_off", n1_rb, 1'b0);
        check("false_no_valid", qsize(1), 0);

        // Reset mid data bit 3 while both TX lines and one RX are in flight.
        n1_txd = 8'h5A; n1_tv = 1'b1;
        e1_txd = 8'h5A; e1_tv = 1'b1;
        @(negedge clk);
        n1_tv = 1'b0; e1_tv = 1'b0;
        k = 0;
        while (n1_tx && k < 50) begin @(negedge clk); k++; end
        t0 = cyc;
        wait_until(t0 + 4 * BT + BT / 2);
        check("mid_busy_pre", {n1_tb, e1_rb}, 2'b11);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", n1_tx, 1'b1);
        check("mid_rst_ready", n1_tr, 1'b1);
        check("mid_rst_busy", {n1_tb, e1_tb, e1_rb}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2500) @(negedge clk);
        check("mid_rst_no_rx", qsize(1) + qsize(2), 0);

        // 9O2 loopback back-to-back 0x1AB, 0x055.
        n9_buf[0] = 9'h1AB; n9_buf[1] = 9'h055;
        n9_burst(2);
        wait_count(4, 2, 5000, "b2b");
        expect_frame(4, "b2b0", 9'h1AB, 1'b0, 1'b0);
        expect_frame(4, "b2b1", 9'h055, 1'b0, 1'b0);

        // Random loopback payloads: the reference model is the identity on the payload.
        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom);
            send_e1(rd);
            wait_count(2, 1, 2500, "rnd_lb");
            expect_frame(2, $sformatf("rnd_lb%0d", i), {1'b0, rd}, 1'b0, 1'b0);
        end

        // Random external 8O1 frames with random parity/stop corruption.
        for (int i = 0; i < 8; i++) begin
            rd  = 8'($urandom);
            rbp = 1'($urandom_range(1, 0));
            rbs = 1'($urandom_range(1, 0));
            send_ext(2, {1'b0, rd}, 8, 1, rbp, rbs);
            wait_count(3, 1, 200, "rnd_ext");
            expect_frame(3, $sformatf("rnd_ext%0d", i), {1'b0, rd}, rbp, rbs);
        end

        // Random 9O2 burst compared in order.
        for (int i = 0; i < 5; i++) n9_buf[i] = 9'($urandom);
        n9_burst(5);
        wait_count(4, 5, 12000, "rnd_b2b");
        for (int i = 0; i < 5; i++) begin
            expect_frame(4, $sformatf("rnd_b2b%0d", i), n9_buf[i], 1'b0, 1'b0);
        end
        check("lb_tx_never_low", e1_tx_low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
